// File: rtl/nascom_decode_ctl.sv
// nascom_decode_ctl: memory-cycle sequencer for the Nascom 2 block-decode PROM.
// Watches Z80 memory requests, drives the 32x2 decode PROM with A15..A11,
// latches its region code and issues registered RAM/ROM chip-selects plus
// per-region wait states.
//
// Optional feature: define NASCOM_RESET_JUMP_EN to build in the power-on
// reset-jump overlay. While it is active every decoded cycle selects ROM; it
// clears on the first M1 fetch from page RJ_PAGE.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   mreq_n, rfsh_n     Z80 memory request / refresh (refresh cycles ignored)
//   m1_n               Z80 opcode fetch (used only by the reset-jump overlay)
//   addr[4:0]          Z80 A15..A11
//   prom_ce_n, prom_a  decode PROM enable and address
//   prom_d[1:0]        decode PROM data {d1,d0}: 00 RAM, 01 ROM, 1x none
//   rom_cs_n, ram_cs_n chip-selects (never both low)
//   wait_n             Z80 WAIT
//   unmapped           one-clock pulse when a cycle decodes to no device
//   rj_active          reset-jump overlay in force
module nascom_decode_ctl #(
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned RAM_WAIT = 0,
  parameter logic [4:0]  RJ_PAGE  = 5'h1C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mreq_n,
  input  logic       rfsh_n,
  input  logic       m1_n,
  input  logic [4:0] addr,
  output logic       prom_ce_n,
  output logic [4:0] prom_a,
  input  logic [1:0] prom_d,
  output logic       rom_cs_n,
  output logic       ram_cs_n,
  output logic       wait_n,
  output logic       unmapped,
  output logic       rj_active
);

  localparam int unsigned WCW = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_LATCH,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t         state;
  logic [WCW-1:0] wcnt;

  logic           rj_force_c;
  logic           sel_rom_c;
  logic           sel_ram_c;
  logic [WCW-1:0] wload_c;
  logic           abort_c;

  // Reset-jump overlay: forces ROM until the terminating fetch, which itself
  // decodes normally.
`ifdef NASCOM_RESET_JUMP_EN
  logic rj_q;
  logic rj_hit_c;

  assign rj_hit_c   = !m1_n && (prom_a == RJ_PAGE);
  assign rj_force_c = rj_q && !rj_hit_c;
  assign rj_active  = rj_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rj_q <= 1'b1;
    end else if (state == ST_LATCH && !mreq_n && rj_hit_c) begin
      rj_q <= 1'b0;
    end
  end
`else
  logic unused_rj;

  assign unused_rj  = !m1_n && (prom_a == RJ_PAGE);
  assign rj_force_c = 1'b0;
  assign rj_active  = 1'b0;
`endif

  // Region decode from the PROM code; 2'b10 is reserved and treated as none.
  always_comb begin
    sel_rom_c = 1'b0;
    sel_ram_c = 1'b0;
    if (rj_force_c) begin
      sel_rom_c = 1'b1;
    end else begin
      case (prom_d)
        2'b00:   sel_ram_c = 1'b1;
        2'b01:   sel_rom_c = 1'b1;
        default: ;
      endcase
    end
  end

  assign wload_c = sel_rom_c ? WCW'(ROM_WAIT) : WCW'(RAM_WAIT);

  // mreq_n released before the cycle reached HOLD.
  assign abort_c = mreq_n &&
                   (state == ST_DECODE || state == ST_LATCH || state == ST_WAIT);

  // Cycle sequencer; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      prom_ce_n <= 1'b1;
      prom_a    <= '0;
      rom_cs_n  <= 1'b1;
      ram_cs_n  <= 1'b1;
      wait_n    <= 1'b1;
      unmapped  <= 1'b0;
    end else begin
      unmapped <= 1'b0;
      if (abort_c) begin
        state     <= ST_IDLE;
        wcnt      <= '0;
        prom_ce_n <= 1'b1;
        prom_a    <= '0;
        rom_cs_n  <= 1'b1;
        ram_cs_n  <= 1'b1;
        wait_n    <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!mreq_n && rfsh_n) begin
              prom_a    <= addr;
              prom_ce_n <= 1'b0;
              wait_n    <= 1'b0;
              state     <= ST_DECODE;
            end
          end

          ST_DECODE: state <= ST_LATCH;

          ST_LATCH: begin
            prom_ce_n <= 1'b1;
            if (sel_rom_c || sel_ram_c) begin
              rom_cs_n <= !sel_rom_c;
              ram_cs_n <= !sel_ram_c;
              wcnt     <= wload_c;
              if (wload_c == '0) begin
                wait_n <= 1'b1;
                state  <= ST_HOLD;
              end else begin
                state  <= ST_WAIT;
              end
            end else begin
              unmapped <= 1'b1;
              wait_n   <= 1'b1;
              state    <= ST_HOLD;
            end
          end

          // Saturating countdown; release WAIT on the edge reaching zero.
          ST_WAIT: begin
            if (wcnt != '0) begin
              wcnt <= wcnt - WCW'(1);
            end
            if (wcnt <= WCW'(1)) begin
              wait_n <= 1'b1;
              state  <= ST_HOLD;
            end
          end

          ST_HOLD: begin
            if (mreq_n) begin
              rom_cs_n <= 1'b1;
              ram_cs_n <= 1'b1;
              state    <= ST_IDLE;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nascom_decode_ctl.sv
// Directed bench for nascom_decode_ctl (ROM_WAIT=3, RAM_WAIT=0).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_nascom_decode_ctl;

`ifdef NASCOM_RESET_JUMP_EN
  localparam logic RJ = 1'b1;
`else
  localparam logic RJ = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       mreq_n;
  logic       rfsh_n;
  logic       m1_n;
  logic [4:0] addr;
  logic       prom_ce_n;
  logic [4:0] prom_a;
  logic [1:0] prom_d;
  logic       rom_cs_n;
  logic       ram_cs_n;
  logic       wait_n;
  logic       unmapped;
  logic       rj_active;

  int n_assert;
  int n_fail;

  nascom_decode_ctl #(
    .ROM_WAIT(3),
    .RAM_WAIT(0),
    .RJ_PAGE (5'h1C)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mreq_n   (mreq_n),
    .rfsh_n   (rfsh_n),
    .m1_n     (m1_n),
    .addr     (addr),
    .prom_ce_n(prom_ce_n),
    .prom_a   (prom_a),
    .prom_d   (prom_d),
    .rom_cs_n (rom_cs_n),
    .ram_cs_n (ram_cs_n),
    .wait_n   (wait_n),
    .unmapped (unmapped),
    .rj_active(rj_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst    = 1'b1;
    mreq_n = 1'b1;
    rfsh_n = 1'b1;
    m1_n   = 1'b1;
    addr   = 5'h00;
    prom_d = 2'b00;
    tick();
    tick();

    // Reset values
    check("rst_prom_ce_n", prom_ce_n, 1);
    check("rst_prom_a", prom_a, 0);
    check("rst_rom_cs_n", rom_cs_n, 1);
    check("rst_ram_cs_n", ram_cs_n, 1);
    check("rst_wait_n", wait_n, 1);
    check("rst_unmapped", unmapped, 0);
    check("rst_rj_active", rj_active, RJ);
    rst = 1'b0;
    tick();
    check("idle_prom_ce_n", prom_ce_n, 1);

`ifdef NASCOM_RESET_JUMP_EN
    // Overlay: m1 fetch at page 0 with RAM code still selects ROM
    mreq_n = 1'b0; m1_n = 1'b0; addr = 5'h00; prom_d = 2'b00;
    tick();
    tick();
    tick();
    check("rj0_rom_cs_n", rom_cs_n, 0);
    check("rj0_ram_cs_n", ram_cs_n, 1);
    check("rj0_wait_n", wait_n, 0);
    check("rj0_rj_active", rj_active, 1);
    tick();
    tick();
    tick();
    check("rj0_wait_end", wait_n, 1);
    mreq_n = 1'b1; m1_n = 1'b1;
    tick();
    check("rj0_release", rom_cs_n, 1);
    // Terminating fetch at RJ_PAGE decodes normally as RAM
    mreq_n = 1'b0; m1_n = 1'b0; addr = 5'h1C;
    tick();
    tick();
    check("rj1_pre_active", rj_active, 1);
    tick();
    check("rj1_ram_cs_n", ram_cs_n, 0);
    check("rj1_rom_cs_n", rom_cs_n, 1);
    check("rj1_wait_n", wait_n, 1);
    check("rj1_rj_active", rj_active, 0);
    mreq_n = 1'b1; m1_n = 1'b1;
    tick();
`endif

    // RAM cycle, zero waits
    mreq_n = 1'b0; addr = 5'h01; prom_d = 2'b00;
    tick();
    check("ram_e0_prom_ce_n", prom_ce_n, 0);
    check("ram_e0_wait_n", wait_n, 0);
    check("ram_e0_prom_a", prom_a, 8'h01);
    check("ram_e0_ram_cs_n", ram_cs_n, 1);
    tick();
    check("ram_e1_wait_n", wait_n, 0);
    check("ram_e1_ram_cs_n", ram_cs_n, 1);
    tick();
    check("ram_e2_ram_cs_n", ram_cs_n, 0);
    check("ram_e2_rom_cs_n", rom_cs_n, 1);
    check("ram_e2_wait_n", wait_n, 1);
    check("ram_e2_prom_ce_n", prom_ce_n, 1);
    mreq_n = 1'b1;
    tick();
    check("ram_end_ram_cs_n", ram_cs_n, 1);

    // ROM cycle, three waits, held four extra clocks
    mreq_n = 1'b0; addr = 5'h00; prom_d = 2'b01;
    tick();
    check("rom_e0_wait_n", wait_n, 0);
    tick();
    check("rom_e1_rom_cs_n", rom_cs_n, 1);
    tick();
    check("rom_e2_rom_cs_n", rom_cs_n, 0);
    check("rom_e2_wait_n", wait_n, 0);
    tick();
    check("rom_e3_wait_n", wait_n, 0);
    tick();
    check("rom_e4_wait_n", wait_n, 0);
    tick();
    check("rom_e5_wait_n", wait_n, 1);
    check("rom_e5_rom_cs_n", rom_cs_n, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rom_hold_rom_cs_n", rom_cs_n, 0);
    end
    mreq_n = 1'b1;
    tick();
    check("rom_end_rom_cs_n", rom_cs_n, 1);
    check("rom_end_ram_cs_n", ram_cs_n, 1);

    // Back-to-back: accepted on the edge right after IDLE re-entry; unmapped
    mreq_n = 1'b0; addr = 5'h10; prom_d = 2'b11;
    tick();
    check("unm_e0_prom_ce_n", prom_ce_n, 0);
    check("unm_e0_unmapped", unmapped, 0);
    tick();
    check("unm_e1_wait_n", wait_n, 0);
    tick();
    check("unm_e2_unmapped", unmapped, 1);
    check("unm_e2_wait_n", wait_n, 1);
    check("unm_e2_rom_cs_n", rom_cs_n, 1);
    check("unm_e2_ram_cs_n", ram_cs_n, 1);
    tick();
    check("unm_e3_unmapped", unmapped, 0);
    mreq_n = 1'b1;
    tick();

    // Reserved code 2'b10 treated as none
    mreq_n = 1'b0; prom_d = 2'b10;
    tick();
    tick();
    tick();
    check("rsv_unmapped", unmapped, 1);
    check("rsv_ram_cs_n", ram_cs_n, 1);
    mreq_n = 1'b1;
    tick();

    // Abort during WAIT
    mreq_n = 1'b0; prom_d = 2'b01;
    tick();
    tick();
    tick();
    check("abw_e2_rom_cs_n", rom_cs_n, 0);
    tick();
    check("abw_e3_wait_n", wait_n, 0);
    mreq_n = 1'b1;
    tick();
    check("abw_wait_n", wait_n, 1);
    check("abw_rom_cs_n", rom_cs_n, 1);
    check("abw_unmapped", unmapped, 0);
    check("abw_prom_a", prom_a, 0);
    tick();
    check("abw_idle_prom_ce_n", prom_ce_n, 1);
    // FSM back in IDLE: a new request is accepted on the next edge
    mreq_n = 1'b0; addr = 5'h03;
    tick();
    check("abw_new_prom_ce_n", prom_ce_n, 0);
    check("abw_new_prom_a", prom_a, 8'h03);

    // Abort during DECODE
    mreq_n = 1'b1;
    tick();
    check("abd_prom_ce_n", prom_ce_n, 1);
    check("abd_wait_n", wait_n, 1);
    tick();
    check("abd_unmapped", unmapped, 0);
    check("abd_rom_cs_n", rom_cs_n, 1);

    // Refresh cycles never leave IDLE
    mreq_n = 1'b0; rfsh_n = 1'b0; prom_d = 2'b00;
    tick();
    tick();
    tick();
    check("rfsh_prom_ce_n", prom_ce_n, 1);
    check("rfsh_wait_n", wait_n, 1);
    check("rfsh_ram_cs_n", ram_cs_n, 1);
    mreq_n = 1'b1; rfsh_n = 1'b1;
    tick();

    // Asynchronous reset in HOLD
    mreq_n = 1'b0; addr = 5'h05; prom_d = 2'b00;
    tick();
    tick();
    tick();
    check("rh_ram_cs_n", ram_cs_n, 0);
    rst = 1'b1;
    #1;
    check("rh_async_ram_cs_n", ram_cs_n, 1);
    check("rh_async_wait_n", wait_n, 1);
    check("rh_async_prom_a", prom_a, 0);
    mreq_n = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rh_rel_ram_cs_n", ram_cs_n, 1);
    check("rh_rel_rom_cs_n", rom_cs_n, 1);
    check("rh_rel_unmapped", unmapped, 0);
    check("rh_rel_rj_active", rj_active, RJ);
    // Next request decodes normally (ROM while the overlay is re-armed)
    mreq_n = 1'b0; addr = 5'h02;
    tick();
    check("rh_new_prom_a", prom_a, 8'h02);
    tick();
    tick();
    check("rh_new_ram_cs_n", ram_cs_n, RJ ? 1 : 0);
    check("rh_new_rom_cs_n", rom_cs_n, RJ ? 0 : 1);
    check("rh_new_wait_n", wait_n, RJ ? 0 : 1);
    mreq_n = 1'b1;
    tick();
    check("rh_new_end_wait_n", wait_n, 1);
    check("rh_new_end_cs", {rom_cs_n, ram_cs_n}, 8'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nascom_decode_ctl.md
# nascom_decode_ctl

Memory-cycle sequencer for the Nascom 2 block-decode PROM. It watches Z80 memory requests, drives the 32x2 decode PROM with the top five address bits and latches its 2-bit result. From that result it issues registered RAM/ROM chip-selects and per-region wait states to the CPU. It also provides the optional power-on reset-jump overlay.

## Interface
Parameters:
- ROM_WAIT, 1: wait-state clocks inserted for ROM region (0..7)
- RAM_WAIT, 0: wait-state clocks inserted for RAM region (0..7)
- RJ_PAGE, 5'h1C: addr[15:11] value that terminates reset-jump overlay

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- mreq_n  in  1  Z80 memory request
- rfsh_n  in  1  Z80 refresh; low = refresh cycle, ignored
- m1_n  in  1  Z80 opcode fetch
- addr  in  5  Z80 A15..A11
- prom_ce_n  out  1  decode PROM enable
- prom_a  out  5  decode PROM address
- prom_d  in  2  decode PROM data {d1,d0}
- rom_cs_n  out  1  ROM chip-select
- ram_cs_n  out  1  RAM chip-select
- wait_n  out  1  Z80 WAIT
- unmapped  out  1  one-clock pulse: cycle decoded to no device
- rj_active  out  1  reset-jump overlay in force

## Operation
- PROM code {d1,d0}: 2'b00 = RAM, 2'b01 = ROM, 2'b11 = none. 2'b10 is reserved and treated as none.
- FSM states:
  - IDLE: on sampled mreq_n=0 and rfsh_n=1, capture addr into prom_a, drive prom_ce_n=0 and wait_n=0, go to DECODE.
  - DECODE: one clock of PROM settle, then go to LATCH.
  - LATCH: register prom_d into region and drive prom_ce_n=1.
    - ROM or RAM: assert the matching cs_n and load wcnt with ROM_WAIT or RAM_WAIT. If wcnt=0, set wait_n=1 and go to HOLD; otherwise go to WAIT.
    - None: pulse unmapped, set wait_n=1, go to HOLD with no cs.
  - WAIT: decrement wcnt each clock. On the edge where wcnt reaches 0, set wait_n=1 and go to HOLD.
  - HOLD: keep cs asserted until mreq_n=1 is sampled. Then deassert all selects and go to IDLE.
- Abort: mreq_n=1 sampled in DECODE, LATCH or WAIT returns the FSM to IDLE on that edge. All outputs go to their reset values; no unmapped pulse.
- Refresh cycles (rfsh_n=0) never leave IDLE.
- wcnt is 3 bits. No wrap: decrementing stops at 0.
- Exactly one of rom_cs_n / ram_cs_n may be low at any time.

## Timing
- Reset values: prom_ce_n=1, prom_a=0, rom_cs_n=1, ram_cs_n=1, wait_n=1, unmapped=0. rj_active=1 if the feature is compiled in, else 0. FSM goes to IDLE and wcnt=0.
- Edge E0 samples mreq_n=0:
  - prom_ce_n=0 and wait_n=0 after E0.
  - cs_n low after E0+2.
  - wait_n high after E0+2+N, where N is the region's wait count.
- Minimum cycle (N=0): wait_n low for exactly 2 clocks.
- The HOLD to IDLE transition takes 1 clock. A new mreq_n=0 may be accepted on the edge immediately after IDLE is re-entered.
- Reset asserted mid-cycle forces reset values asynchronously. No cs or unmapped glitch is produced on release.

## Configuration
- NASCOM_RESET_JUMP_EN defined:
  - rj_active=1 out of reset.
  - While rj_active=1, every decoded cycle is treated as ROM, regardless of prom_d, and uses ROM_WAIT.
  - rj_active clears on the LATCH edge of the first cycle with m1_n=0 and prom_a=RJ_PAGE. That cycle is itself decoded normally from prom_d.
- NASCOM_RESET_JUMP_EN undefined:
  - rj_active is tied 0 and the overlay logic is absent.
  - Decode uses prom_d only.

## Test plan
- Reset released, macro undefined, prom_d=2'b00, mreq_n low at addr=5'h01 with RAM_WAIT=0 -> ram_cs_n low 2 clocks after sample, wait_n low exactly 2 clocks, rom_cs_n stays 1.
- prom_d=2'b01, ROM_WAIT=3 -> rom_cs_n low after E0+2, wait_n low 5 clocks. Holding mreq_n low 4 more clocks keeps rom_cs_n low until the edge after mreq_n=1 is sampled.
- prom_d=2'b11 -> unmapped high exactly 1 clock at LATCH, no cs, wait_n low 2 clocks.
- mreq_n raised during WAIT (ROM_WAIT=7, after 2 wait clocks) -> next edge: wait_n=1, rom_cs_n=1, FSM in IDLE, no unmapped.
- rst pulsed while in HOLD with ram_cs_n low -> ram_cs_n=1, wait_n=1 immediately. Next mreq_n=0 after release is decoded normally.
- Macro defined, prom_d=2'b00 at all addresses:
  - m1 fetches at addr 5'h00 -> rom_cs_n asserted, rj_active stays 1.
  - m1 fetch at 5'h1C -> rj_active drops at LATCH; that cycle and later ones select RAM.
